// File: rtl/wb_gain_ctrl.sv
// wb_gain_ctrl -- white-balance gain controller.
//
// Accepts per-frame R/G/B channel sums, computes the red and blue gains
// rk = (G << 8) / R and bk = (G << 8) / B in U10.8 using one shared restoring
// divider (18 cycles per quotient, red first, then blue), parks the results in
// shadow registers and commits them to rk/bk only at frame_sync. A manual
// override can be committed at frame_sync instead.
//
// Build option:
//   WB_GAIN_CLAMP_EN  defined   -> computed quotients are clamped to [GAIN_MIN, GAIN_MAX]
//                     undefined -> only saturation at 18'h3FFFF; GAIN_MIN/GAIN_MAX unused
//
// Ports:
//   clk, rst_n                clock; asynchronous active-low reset
//   stat_valid, stat_ready    handshake for the frame sums (ready only while idle)
//   sum_r, sum_g, sum_b       32-bit frame channel sums (sum_g = mean of both G sites)
//   frame_sync                frame-boundary pulse, the only point where rk/bk change
//   manual_en                 commit manual_rk/manual_bk instead of computed gains
//   manual_rk, manual_bk      manual gains, U10.8
//   rk, bk                    committed gains, U10.8 (18'h100 = 1.0)
//   gain_update               one-cycle pulse in the cycle after rk/bk are written
//   busy                      divider running

module wb_gain_ctrl #(
    parameter logic [17:0] GAIN_MAX = 18'h400,
    parameter logic [17:0] GAIN_MIN = 18'h080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stat_valid,
    output logic        stat_ready,
    input  logic [31:0] sum_r,
    input  logic [31:0] sum_g,
    input  logic [31:0] sum_b,
    input  logic        frame_sync,
    input  logic        manual_en,
    input  logic [17:0] manual_rk,
    input  logic [17:0] manual_bk,
    output logic [17:0] rk,
    output logic [17:0] bk,
    output logic        gain_update,
    output logic        busy
);

    localparam logic [17:0] UNITY   = 18'h100;
    localparam logic [17:0] SAT_MAX = 18'h3FFFF;
    localparam logic [4:0]  LAST    = 5'd17;

    typedef enum logic [2:0] {
        StIdle = 3'b001,
        StDivR = 3'b010,
        StDivB = 3'b100
    } state_e;

    state_e      state_q;
    logic [31:0] sum_r_q, sum_g_q, sum_b_q;
    logic [31:0] rem_q;
    logic [17:0] lo_q;          // low dividend bits still to be brought down, MSB next
    logic [16:0] quo_q;         // quotient bits produced so far
    logic [4:0]  cnt_q;
    logic [17:0] shadow_rk_q, shadow_bk_q;
    logic        pending_q;
    logic [17:0] rk_q, bk_q;
    logic        gain_update_q;

    logic [31:0] den;
    logic [32:0] trial;
    logic        q_bit;
    logic [31:0] rem_d;
    logic [17:0] quo_d;
    logic        ovf;
    logic [17:0] quo_sat;
    logic [17:0] gain_res;
    logic        last_step;
    logic        div_done;

    // One restoring-division step plus result formatting. The dividend is
    // {sum_g, 8'h00} (40 bits); its top 22 bits seed the remainder and the low
    // 18 bits are shifted in one per cycle, giving one quotient bit per cycle.
    always_comb begin
        den      = (state_q == StDivB) ? sum_b_q : sum_r_q;
        trial    = {rem_q, lo_q[17]};
        q_bit    = (trial >= {1'b0, den});
        // When q_bit is set the true difference is below den, so 32 bits suffice.
        rem_d    = q_bit ? (trial[31:0] - den) : trial[31:0];
        quo_d    = {quo_q, q_bit};
        // Quotient would need more than 18 bits: (g << 8) >= (den << 18).
        ovf      = ({10'b0, sum_g_q[31:10]} >= den);
        quo_sat  = ovf ? SAT_MAX : quo_d;
`ifdef WB_GAIN_CLAMP_EN
        if (quo_sat > GAIN_MAX) begin
            quo_sat = GAIN_MAX;
        end else if (quo_sat < GAIN_MIN) begin
            quo_sat = GAIN_MIN;
        end
`endif
        // A zero channel sum carries no colour information: fall back to unity,
        // deliberately outside the clamp window.
        gain_res = (den == '0) ? UNITY : quo_sat;
    end

    assign last_step = (cnt_q == LAST);
    assign div_done  = (state_q == StDivB) && last_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            sum_r_q       <= '0;
            sum_g_q       <= '0;
            sum_b_q       <= '0;
            rem_q         <= '0;
            lo_q          <= '0;
            quo_q         <= '0;
            cnt_q         <= '0;
            shadow_rk_q   <= UNITY;
            shadow_bk_q   <= UNITY;
            pending_q     <= 1'b0;
            rk_q          <= UNITY;
            bk_q          <= UNITY;
            gain_update_q <= 1'b0;
        end else begin
            gain_update_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (stat_valid) begin
                        sum_r_q <= sum_r;
                        sum_g_q <= sum_g;
                        sum_b_q <= sum_b;
                        rem_q   <= {10'b0, sum_g[31:10]};
                        lo_q    <= {sum_g[9:0], 8'h00};
                        quo_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= StDivR;
                    end
                end
                StDivR: begin
                    if (last_step) begin
                        shadow_rk_q <= gain_res;
                        // Reseed the divider for the blue channel.
                        rem_q       <= {10'b0, sum_g_q[31:10]};
                        lo_q        <= {sum_g_q[9:0], 8'h00};
                        quo_q       <= '0;
                        cnt_q       <= '0;
                        state_q     <= StDivB;
                    end else begin
                        rem_q <= rem_d;
                        lo_q  <= {lo_q[16:0], 1'b0};
                        quo_q <= quo_d[16:0];
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                StDivB: begin
                    if (last_step) begin
                        shadow_bk_q <= gain_res;
                        pending_q   <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        rem_q <= rem_d;
                        lo_q  <= {lo_q[16:0], 1'b0};
                        quo_q <= quo_d[16:0];
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Commit point. A result finishing in this very cycle is not yet
            // committable and keeps pending set for the next frame_sync.
            if (frame_sync) begin
                if (manual_en) begin
                    rk_q          <= manual_rk;
                    bk_q          <= manual_bk;
                    gain_update_q <= 1'b1;
                    if (!div_done) begin
                        pending_q <= 1'b0;
                    end
                end else if (pending_q && !div_done) begin
                    rk_q          <= shadow_rk_q;
                    bk_q          <= shadow_bk_q;
                    pending_q     <= 1'b0;
                    gain_update_q <= 1'b1;
                end
            end
        end
    end

    // An inverted clamp window would make the clamp result order-dependent.
    always_ff @(posedge clk) begin
        assert (GAIN_MIN <= GAIN_MAX);
    end

    assign stat_ready  = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign rk          = rk_q;
    assign bk          = bk_q;
    assign gain_update = gain_update_q;

endmodule

// File: tb/tb_wb_gain_ctrl.sv
// Testbench for wb_gain_ctrl: directed scenarios plus randomized traffic,
// checked against a timeline model computed from arithmetic quotients.

module tb_wb_gain_ctrl;

    localparam logic [17:0] GAIN_MAX = 18'h400;
    localparam logic [17:0] GAIN_MIN = 18'h080;
    localparam logic [17:0] UNITY    = 18'h100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stat_valid = 1'b0;
    logic        stat_ready;
    logic [31:0] sum_r = '0, sum_g = '0, sum_b = '0;
    logic        frame_sync = 1'b0;
    logic        manual_en = 1'b0;
    logic [17:0] manual_rk = '0, manual_bk = '0;
    logic [17:0] rk, bk;
    logic        gain_update;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: committed/shadow gains, pending flag and the
    // number of cycles left before the current computation finishes.
    logic [17:0] m_rk, m_bk, m_srk, m_sbk;
    bit          m_pend;
    int          m_left;
    bit          m_upd;
    logic [31:0] m_r, m_g, m_b;

    always #5 clk = ~clk;

    wb_gain_ctrl #(
        .GAIN_MAX(GAIN_MAX),
        .GAIN_MIN(GAIN_MIN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stat_valid (stat_valid),
        .stat_ready (stat_ready),
        .sum_r      (sum_r),
        .sum_g      (sum_g),
        .sum_b      (sum_b),
        .frame_sync (frame_sync),
        .manual_en  (manual_en),
        .manual_rk  (manual_rk),
        .manual_bk  (manual_bk),
        .rk         (rk),
        .bk         (bk),
        .gain_update(gain_update),
        .busy       (busy)
    );

    function automatic logic [17:0] ref_gain(input logic [31:0] g, input logic [31:0] d);
        longint unsigned q;
        if (d == 0) return UNITY;
        q = ({32'b0, g} << 8) / {32'b0, d};
        if (q > 64'h3FFFF) q = 64'h3FFFF;
`ifdef WB_GAIN_CLAMP_EN
        if (q > 64'(GAIN_MAX)) q = 64'(GAIN_MAX);
        if (q < 64'(GAIN_MIN)) q = 64'(GAIN_MIN);
`endif
        return q[17:0];
    endfunction

    function automatic logic [31:0] rnd_sum();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return $urandom;
            default: return 32'($urandom_range(100, 20000));
        endcase
    endfunction

    task automatic model_reset();
        m_rk = UNITY; m_bk = UNITY; m_srk = UNITY; m_sbk = UNITY;
        m_pend = 0; m_left = 0; m_upd = 0;
    endtask

    // Advance one clock; the model consumes the inputs present at that edge.
    // red gain lands 18 cycles after acceptance, blue gain and pending at 36.
    task automatic tick();
        bit done;
        done  = (m_left == 1);
        m_upd = 0;
        if (rst_n) begin
            if (frame_sync) begin
                if (manual_en) begin
                    m_rk = manual_rk; m_bk = manual_bk; m_upd = 1; m_pend = 0;
                end else if (m_pend && !done) begin
                    m_rk = m_srk; m_bk = m_sbk; m_upd = 1; m_pend = 0;
                end
            end
            if (m_left == 19) m_srk = ref_gain(m_g, m_r);
            if (done) begin
                m_sbk  = ref_gain(m_g, m_b);
                m_pend = 1;
            end
            if (m_left > 0) m_left--;
            else if (stat_valid) begin
                m_r = sum_r; m_g = sum_g; m_b = sum_b; m_left = 36;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stat_valid = 0; frame_sync = 0; manual_en = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        tick();
        rst_n = 1;
    endtask

    task automatic send(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
        sum_r = r; sum_g = g; sum_b = b; stat_valid = 1;
        tick();
        stat_valid = 0;
    endtask

    task automatic sync_pulse(input bit man, input logic [17:0] mrk, input logic [17:0] mbk);
        manual_en = man; manual_rk = mrk; manual_bk = mbk; frame_sync = 1;
        tick();
        frame_sync = 0; manual_en = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        tick();
        tick();
        n_cmp++; if (stat_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b required 1", stat_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_cmp++; if (rk !== UNITY || bk !== UNITY) begin n_err++; $display("FAIL rst_gains: got %h/%h required %h", rk, bk, UNITY); end
        n_cmp++; if (gain_update !== 1'b0) begin n_err++; $display("FAIL rst_upd: got %b required 0", gain_update); end
        rst_n = 1;
        #1;
        n_cmp++; if (stat_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready: got %b required 1", stat_ready); end
        tick();
        n_cmp++; if (stat_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL idle_after_rel: got ready=%b busy=%b required 1/0", stat_ready, busy); end
    endtask

    task automatic test_ratio();
        int nbusy = 0;
        do_reset();
        send(32'd1000, 32'd2000, 32'd500);
        for (int c = 1; c < 40; c++) begin
            if (busy) nbusy++;
            if (c == 39) begin
                n_cmp++; if (rk !== UNITY || bk !== UNITY) begin n_err++; $display("FAIL ratio_hold: got %h/%h required %h", rk, bk, UNITY); end
            end
            tick();
        end
        sync_pulse(0, '0, '0);
        n_cmp++; if (rk !== 18'h200) begin n_err++; $display("FAIL ratio_rk: got %h required %h", rk, 18'h200); end
        n_cmp++; if (bk !== 18'h400) begin n_err++; $display("FAIL ratio_bk: got %h required %h", bk, 18'h400); end
        n_cmp++; if (gain_update !== 1'b1) begin n_err++; $display("FAIL ratio_upd: got %b required 1", gain_update); end
        tick();
        n_cmp++; if (gain_update !== 1'b0) begin n_err++; $display("FAIL ratio_upd_pulse: got %b required 0", gain_update); end
        n_cmp++; if (nbusy != 36) begin n_err++; $display("FAIL ratio_busy_len: got %0d required 36", nbusy); end
    endtask

    task automatic test_den_zero();
        int n = 0;
        do_reset();
        send(32'd0, 32'd5000, 32'd2500);
        while (!stat_ready && n < 80) begin tick(); n++; end
        n_cmp++; if (n != 36) begin n_err++; $display("FAIL dz_ready_len: got %0d required 36", n); end
        sync_pulse(0, '0, '0);
        n_cmp++; if (rk !== UNITY || bk !== 18'h200) begin n_err++; $display("FAIL dz_gains: got %h/%h required %h/%h", rk, bk, UNITY, 18'h200); end
        n_cmp++; if (gain_update !== 1'b1) begin n_err++; $display("FAIL dz_upd: got %b required 1", gain_update); end
    endtask

    task automatic test_clamp();
        logic [17:0] exp_rk;
`ifdef WB_GAIN_CLAMP_EN
        exp_rk = 18'h400;
`else
        exp_rk = 18'h800;
`endif
        do_reset();
        send(32'd1000, 32'd8000, 32'd16000);
        repeat (40) tick();
        sync_pulse(0, '0, '0);
        n_cmp++; if (rk !== exp_rk) begin n_err++; $display("FAIL clamp_rk: got %h required %h", rk, exp_rk); end
        n_cmp++; if (bk !== 18'h080) begin n_err++; $display("FAIL clamp_bk: got %h required %h", bk, 18'h080); end
    endtask

    task automatic test_manual();
        int n = 0;
        do_reset();
        send(32'd1000, 32'd2000, 32'd500);
        repeat (9) tick();
        sync_pulse(1, 18'h1A0, 18'h0F0);
        n_cmp++; if (rk !== 18'h1A0 || bk !== 18'h0F0) begin n_err++; $display("FAIL man_gains: got %h/%h required 1a0/0f0", rk, bk); end
        n_cmp++; if (gain_update !== 1'b1) begin n_err++; $display("FAIL man_upd: got %b required 1", gain_update); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL man_busy: got %b required 1", busy); end
        while (!stat_ready && n < 80) begin tick(); n++; end
        n_cmp++; if (stat_ready !== 1'b1) begin n_err++; $display("FAIL man_timeout: got ready=%b required 1", stat_ready); end
        // Finished after the manual sync, so still committable.
        sync_pulse(0, '0, '0);
        n_cmp++; if (rk !== 18'h200 || bk !== 18'h400) begin n_err++; $display("FAIL man_later: got %h/%h required 200/400", rk, bk); end
        // A result finished before a manual sync is discarded.
        send(32'd1000, 32'd8000, 32'd16000);
        repeat (40) tick();
        sync_pulse(1, 18'h123, 18'h0AB);
        tick();
        sync_pulse(0, '0, '0);
        n_cmp++; if (rk !== 18'h123 || bk !== 18'h0AB) begin n_err++; $display("FAIL man_discard: got %h/%h required 123/0ab", rk, bk); end
        n_cmp++; if (gain_update !== 1'b0) begin n_err++; $display("FAIL man_discard_upd: got %b required 0", gain_update); end
    endtask

    task automatic test_sync_at_done();
        do_reset();
        send(32'd1000, 32'd1000, 32'd1000);
        repeat (35) tick();
        frame_sync = 1;
        tick();
        frame_sync = 0;
        n_cmp++; if (gain_update !== 1'b0 || rk !== UNITY || bk !== UNITY) begin n_err++; $display("FAIL sad_nocommit: got upd=%b %h/%h required 0 100/100", gain_update, rk, bk); end
        repeat (2) tick();
        sync_pulse(0, '0, '0);
        n_cmp++; if (gain_update !== 1'b1 || rk !== UNITY || bk !== UNITY) begin n_err++; $display("FAIL sad_next: got upd=%b %h/%h required 1 100/100", gain_update, rk, bk); end
    endtask

    task automatic test_reset_mid_div();
        do_reset();
        sync_pulse(1, 18'h155, 18'h0CC);
        send(32'd1000, 32'd2000, 32'd500);
        repeat (9) tick();
        rst_n = 0;
        model_reset();
        #1;
        n_cmp++; if (busy !== 1'b0 || stat_ready !== 1'b1) begin n_err++; $display("FAIL mrst_state: got busy=%b ready=%b required 0/1", busy, stat_ready); end
        n_cmp++; if (rk !== UNITY || bk !== UNITY || gain_update !== 1'b0) begin n_err++; $display("FAIL mrst_outs: got %h/%h upd=%b required 100/100 0", rk, bk, gain_update); end
        tick();
        rst_n = 1;
        repeat (40) tick();
        sync_pulse(0, '0, '0);
        n_cmp++; if (gain_update !== 1'b0 || rk !== UNITY) begin n_err++; $display("FAIL mrst_nosync: got upd=%b rk=%h required 0 100", gain_update, rk); end
        n_cmp++; if (stat_ready !== 1'b1) begin n_err++; $display("FAIL mrst_ready: got %b required 1", stat_ready); end
        send(32'd3000, 32'd4000, 32'd700);
        repeat (38) tick();
        sync_pulse(0, '0, '0);
        n_cmp++; if (rk !== m_rk || bk !== m_bk) begin n_err++; $display("FAIL mrst_fresh: got %h/%h required %h/%h", rk, bk, m_rk, m_bk); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        sum_r = 32'd1200; sum_g = 32'd3000; sum_b = 32'd900;
        stat_valid = 1;
        for (int c = 0; c < 100; c++) begin
            if (!stat_ready) begin
                sum_r = rnd_sum(); sum_g = rnd_sum(); sum_b = rnd_sum();
            end
            n_cmp++; if (stat_ready !== (m_left == 0)) begin n_err++; $display("FAIL b2b_ready c%0d: got %b required %b", c, stat_ready, m_left == 0); end
            tick();
        end
        stat_valid = 0;
        repeat (40) tick();
        sync_pulse(0, '0, '0);
        n_cmp++; if (rk !== m_rk || bk !== m_bk) begin n_err++; $display("FAIL b2b_gains: got %h/%h required %h/%h", rk, bk, m_rk, m_bk); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            stat_valid = ($urandom_range(0, 2) == 0);
            sum_r      = rnd_sum();
            sum_g      = rnd_sum();
            sum_b      = rnd_sum();
            frame_sync = ($urandom_range(0, 24) == 0);
            manual_en  = ($urandom_range(0, 3) == 0);
            manual_rk  = 18'($urandom);
            manual_bk  = 18'($urandom);
            tick();
            n_cmp++; if (rk !== m_rk || bk !== m_bk) begin n_err++; $display("FAIL rnd_gains c%0d: got %h/%h required %h/%h", c, rk, bk, m_rk, m_bk); end
            n_cmp++; if (gain_update !== m_upd) begin n_err++; $display("FAIL rnd_upd c%0d: got %b required %b", c, gain_update, m_upd); end
            n_cmp++; if (stat_ready !== (m_left == 0) || busy !== (m_left != 0)) begin n_err++; $display("FAIL rnd_hs c%0d: got ready=%b busy=%b required left=%0d", c, stat_ready, busy, m_left); end
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ratio();
        test_den_zero();
        test_clamp();
        test_manual();
        test_sync_at_done();
        test_reset_mid_div();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
